// File: rtl/mem_request_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_request_arbiter_pkg                                          |
// | Shared types and arbitration-mode constants for the arbiter.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package mem_request_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    HALTED = 2'd3
  } arb_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_t;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

endpackage
`default_nettype wire

// File: rtl/mem_request_arbiter_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter                                                       |
// | Combinational round-robin / fixed-priority channel selector.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module rr_arbiter
  import mem_request_arbiter_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int IDX_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0]   pending_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic             mode_i,
  output logic             valid_o,
  output logic [NCH-1:0]   grant_o,
  output logic [IDX_W-1:0] grant_idx_o
);

  always_comb begin
    valid_o     = 1'b0;
    grant_idx_o = '0;
    grant_o     = '0;
    if (int'(mode_i) == PRIO_FIXED) begin
      for (int i = 0; i < NCH; i++) begin
        if (pending_i[i]) begin
          valid_o     = 1'b1;
          grant_idx_o = IDX_W'(i);
        end
      end
    end else begin
      // Scan farthest-first so the channel nearest after the pointer is written last.
      for (int k = NCH; k >= 1; k--) begin
        if (pending_i[(int'(ptr_i) + k) % NCH]) begin
          valid_o     = 1'b1;
          grant_idx_o = IDX_W'((int'(ptr_i) + k) % NCH);
        end
      end
    end
    if (valid_o) begin
      grant_o[grant_idx_o] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_request_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_request_arbiter                                              |
// | Grants one of NCH requesters onto a single memory port.          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mem_request_arbiter
  import mem_request_arbiter_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 255
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  halt,
  input  logic [NCH-1:0]        req_ren,
  input  logic [NCH-1:0]        req_wen,
  input  logic [NCH*ADDR_W-1:0] req_addr,
  input  logic [NCH*DATA_W-1:0] req_wdata,
  output logic [NCH-1:0]        req_hit,
  output logic [NCH-1:0]        req_err,
  output logic [DATA_W-1:0]     req_rdata,
  output logic                  mem_ren,
  output logic                  mem_wen,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_store,
  input  logic [DATA_W-1:0]     mem_load,
  input  logic                  mem_wait,
  output logic                  busy,
  output logic                  halted
);

  localparam int               IDX_W    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NCH - 1);

  arb_state_t        state_q, state_d;
  arb_op_t           op_q, op_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
  logic [NCH-1:0]    grant_oh_q, grant_oh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] store_q, store_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ren_q, ren_d;
  logic              wen_q, wen_d;
  logic [NCH-1:0]    hit_q, hit_d;
  logic [NCH-1:0]    err_q, err_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;

  logic [ADDR_W-1:0] ch_addr  [NCH];
  logic [DATA_W-1:0] ch_wdata [NCH];
  logic [NCH-1:0]    pending;
  logic              arb_valid;
  logic [NCH-1:0]    arb_grant;
  logic [IDX_W-1:0]  arb_idx;

  generate
    for (genvar g = 0; g < NCH; g++) begin : g_unpack
      assign ch_addr[g]  = req_addr[g*ADDR_W +: ADDR_W];
      assign ch_wdata[g] = req_wdata[g*DATA_W +: DATA_W];
    end
  endgenerate

  assign pending = req_ren | req_wen;

  rr_arbiter #(
    .NCH   (NCH),
    .IDX_W (IDX_W)
  ) u_arb (
    .pending_i   (pending),
    .ptr_i       (ptr_q),
    .mode_i      (PRIO_MODE == PRIO_FIXED),
    .valid_o     (arb_valid),
    .grant_o     (arb_grant),
    .grant_idx_o (arb_idx)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    ptr_d       = ptr_q;
    grant_idx_d = grant_idx_q;
    grant_oh_d  = grant_oh_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    store_d     = store_q;
    rdata_d     = rdata_q;
    ren_d       = ren_q;
    wen_d       = wen_q;
    hit_d       = '0;
    err_d       = '0;

    case (state_q)
      IDLE: begin
        if (halt) begin
          state_d = HALTED;
        end else if (arb_valid) begin
          grant_idx_d = arb_idx;
          grant_oh_d  = arb_grant;
          addr_d      = ch_addr[arb_idx];
          store_d     = ch_wdata[arb_idx];
          op_d        = req_wen[arb_idx] ? OP_WRITE : OP_READ;
          wen_d       = req_wen[arb_idx];
          ren_d       = req_ren[arb_idx] & ~req_wen[arb_idx];
          cnt_d       = '0;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (!mem_wait) begin
          if (op_q == OP_READ) begin
            rdata_d = mem_load;
          end
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          hit_d   = grant_oh_q;
          ptr_d   = grant_idx_q;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          err_d   = grant_oh_q;
          ptr_d   = grant_idx_q;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = halt ? HALTED : IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = halt ? HALTED : IDLE;
      end
      default: begin
        state_d = HALTED;
      end
    endcase

    // Parking quiesces the memory side; a timeout err pulse may still coincide.
    if (state_d == HALTED) begin
      ren_d   = 1'b0;
      wen_d   = 1'b0;
      addr_d  = '0;
      store_d = '0;
      rdata_d = '0;
      hit_d   = '0;
    end
    busy_d   = (state_d == ACCESS) || (state_d == RESP);
    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      op_q        <= OP_READ;
      ptr_q       <= PTR_RST;
      grant_idx_q <= '0;
      grant_oh_q  <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      store_q     <= '0;
      rdata_q     <= '0;
      ren_q       <= 1'b0;
      wen_q       <= 1'b0;
      hit_q       <= '0;
      err_q       <= '0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ptr_q       <= ptr_d;
      grant_idx_q <= grant_idx_d;
      grant_oh_q  <= grant_oh_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      store_q     <= store_d;
      rdata_q     <= rdata_d;
      ren_q       <= ren_d;
      wen_q       <= wen_d;
      hit_q       <= hit_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
    end
  end

  assign req_hit   = hit_q;
  assign req_err   = err_q;
  assign req_rdata = rdata_q;
  assign mem_ren   = ren_q;
  assign mem_wen   = wen_q;
  assign mem_addr  = addr_q;
  assign mem_store = store_q;
  assign busy      = busy_q;
  assign halted    = halted_q;

endmodule
`default_nettype wire

// File: doc/mem_request_arbiter.md
Name: mem_request_arbiter

Overview:
Parametrised successor to the single-channel imem/dmem request logic. It accepts read and write requests from NCH requester channels, such as instruction fetch and data access, and grants one at a time onto a single memory port. It latches the winning request, holds the memory enables until the memory completes, and returns a one-cycle hit to the granted channel. It also provides selectable arbitration, an access timeout with an error pulse, and a halt-drain sequence. It sits between the datapath request sources and the memory controller.

Parameters:
NCH, 2, number of requester channels (>=2); by convention ch0 = instruction fetch, ch1 = data
ADDR_W, 32, address width
DATA_W, 32, data width
PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority, highest index wins (data over fetch)
TIMEOUT, 255, max ACCESS cycles before abort; the counter is $clog2(TIMEOUT+1) bits wide

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
halt  in  1  stop issuing new grants; drain the current access, then park
req_ren  in  NCH  per-channel read request (level)
req_wen  in  NCH  per-channel write request (level)
req_addr  in  NCH*ADDR_W  per-channel address; channel i occupies [i*ADDR_W +: ADDR_W]
req_wdata  in  NCH*DATA_W  per-channel store data
req_hit  out  NCH  one-cycle completion pulse, one-hot
req_err  out  NCH  one-cycle timeout pulse, one-hot
req_rdata  out  DATA_W  load data; valid while the corresponding req_hit is high
mem_ren  out  1  memory read enable
mem_wen  out  1  memory write enable
mem_addr  out  ADDR_W  latched address
mem_store  out  DATA_W  latched store data
mem_load  in  DATA_W  memory read data
mem_wait  in  1  memory busy; 0 at a rising edge in ACCESS means the access is complete
busy  out  1  high in ACCESS and RESP
halted  out  1  high in HALTED

Behaviour:
- Reset is asynchronous on nRST low:
  - all outputs are 0; state is IDLE
  - the round-robin pointer is NCH-1, so ch0 wins first
  - the timeout counter and latches are cleared
  - a reset mid-ACCESS aborts the access immediately; no hit or err is issued.
- All outputs are registered.
- States are IDLE, ACCESS, RESP, HALTED.
- IDLE:
  - if halt=1, go to HALTED with no grant, even when requests are pending
  - otherwise pending[i] = req_ren[i] | req_wen[i]
  - if any channel is pending, at the edge: latch grant, address, wdata and op; set mem_wen (write) or mem_ren (read); clear the counter; go to ACCESS.
  - if req_ren and req_wen are both high on one channel, the write wins and mem_ren stays 0.
- Arbitration:
  - PRIO_MODE=0: search upward from pointer+1, wrapping mod NCH; the pointer updates to the granted index on completion or abort.
  - PRIO_MODE=1: the highest pending index wins and the pointer is unused.
- ACCESS:
  - mem_ren/mem_wen, mem_addr and mem_store stay stable; requester-side changes are ignored.
  - on an edge with mem_wait=0: capture mem_load into req_rdata (reads only; writes leave rdata unchanged), drop the mem enables, set req_hit[grant], go to RESP.
  - otherwise the counter increments; when it reaches TIMEOUT with mem_wait still 1, drop the enables, set req_err[grant] (no hit) and go to IDLE, or to HALTED if halt=1.
- RESP:
  - req_hit is high for exactly one cycle, then cleared.
  - next state is IDLE, or HALTED if halt=1.
- Requester rule: a requester must change or drop its request on the edge that ends its hit cycle. A request still held in IDLE is treated as a new request.
- Minimum latency is 2 edges from request sampled to hit visible: IDLE at edge k, ACCESS completes at edge k+1, hit is high during cycle k+1.
- Halt asserted during ACCESS or RESP does not abort the access. The access completes normally, then the block enters HALTED.
- HALTED: halted=1 and all other outputs are 0. The state is absorbing until nRST.
- A deasserted request during ACCESS does not cancel the access; the hit is still issued.

Decomposition:
- Shared package: the arb_state_t enum (IDLE, ACCESS, RESP, HALTED), arb_op_t (OP_READ, OP_WRITE), and the PRIO_RR/PRIO_FIXED constants.
- One sub-module: rr_arbiter. It is combinational, maps pending[NCH], pointer and mode to a one-hot grant plus index, and is reusable by the future bus arbiter.

Test Plan:
- Single read: ch0 ren, addr 0x0000_0040, mem_load 0x1234_5678, mem_wait=0 -> mem_ren=1 for 1 cycle at addr 0x40; req_hit=2'b01 for 1 cycle with rdata 0x1234_5678, 2 edges after the request.
- Contention, RR mode: ch0 ren and ch1 wen held continuously, mem_wait=0 -> grants alternate 0,1,0,1 with ch0 first after reset; mem_wen only on ch1 grants.
- Fixed mode (PRIO_MODE=1): ch0 and ch1 both pending -> ch1 served first; ch0 served next, only after ch1 drops.
- Wait states and timeout: mem_wait=1 for 3 cycles -> hit after 5 edges. With TIMEOUT=4 and mem_wait stuck high -> req_err pulse on the granted channel, no hit, enables low, back to IDLE.
- Halt: halt raised mid-ACCESS with mem_wait=1 for 2 cycles -> the access completes and hits, then halted=1. Further requests produce no mem_ren or mem_wen.
- Async reset mid-ACCESS: nRST low between edges -> mem_ren, busy and req_hit drop immediately. After release, ch0 is granted first.
